// File: rtl/row_render_pkg.sv
// Shared constants, colour packing and region encodings for the scanline renderer.
package row_render_pkg;

    localparam int RGB_W = 6;
    localparam int CH_W  = 2;

    // Line geometry, held at 11 bits so wall bounds never wrap.
    localparam logic [10:0] H_VIS = 11'd640;
    localparam logic [10:0] H_MID = 11'd320;

    // Screen regions walked across each visible line.
    typedef enum logic [1:0] {
        BLANK = 2'd0,
        SKY   = 2'd1,
        WALL  = 2'd2,
        FLOOR = 2'd3
    } region_t;

    // Packs three 2-bit channels into {r, g, b}.
    function automatic logic [RGB_W-1:0] packRgb(input logic [CH_W-1:0] r,
                                                 input logic [CH_W-1:0] g,
                                                 input logic [CH_W-1:0] b);
        return {r, g, b};
    endfunction

    localparam logic [RGB_W-1:0] SKY_RGB   = 6'b01_01_11;
    localparam logic [RGB_W-1:0] FLOOR_RGB = 6'b01_01_01;

endpackage

// File: rtl/row_render_if.sv
// Pixel-side bus between the beam timing / wall tracer and the row renderer.
// There is no handshake: every clock carries one pixel position, and o_rgb
// answers the hpos/visible presented exactly two clocks earlier. i_size,
// i_side and i_tex are only sampled on the clock after hmax (line start).
// state is a debug view of the renderer's region FSM.
interface row_render_if;
    import row_render_pkg::*;

    logic [9:0]       hpos;
    logic             hmax;
    logic             visible;
    logic [10:0]      i_size;
    logic             i_side;
    logic [5:0]       i_tex;
    logic [RGB_W-1:0] o_rgb;
    region_t          state;

    modport master (
        output hpos, hmax, visible, i_size, i_side, i_tex,
        input  o_rgb, state
    );

    modport slave (
        input  hpos, hmax, visible, i_size, i_side, i_tex,
        output o_rgb, state
    );

endinterface

// File: rtl/row_render_tex_stepper.sv
// Texture row stepper: advances v by size/32 pixels per texel using an
// error accumulator instead of a divider. At most one step per pixel.
module tex_stepper (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [10:0] size,
    output logic [5:0]  v
);

    logic [11:0] acc;
    logic [11:0] accAdd;
    logic [11:0] sizeExt;

    assign accAdd  = acc + 12'd32;
    assign sizeExt = {1'b0, size};

    // Accumulate 32 per wall pixel; each time the error reaches size, step v.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            v   <= '0;
        end else if (clear) begin
            acc <= '0;
            v   <= '0;
        end else if (en) begin
            if (accAdd >= sizeExt) begin
                acc <= accAdd - sizeExt;
                v   <= (v == 6'd63) ? v : v + 6'd1;
            end else begin
                acc <= accAdd;
            end
        end
    end

endmodule

// File: rtl/row_render.sv
// Per-scanline pixel generator: captures the traced wall at line start and
// emits sky, textured wall or floor colour with a fixed two-clock latency.
// Sync signals travelling alongside must be delayed by two clocks upstream.
module row_render
    import row_render_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    row_render_if.slave   bus
);

    logic        lineStart;
    logic [9:0]  hposD;
    logic        visibleD;
    logic [10:0] sizeR;
    logic        sideR;
    logic [5:0]  uR;
    logic [10:0] wallStart;
    logic [10:0] wallEnd;

    region_t          state;
    region_t          region;
    region_t          nextState;
    logic [10:0]      hposNext;
    logic [5:0]       v;
    logic [5:0]       t;
    logic [RGB_W-1:0] texel;
    logic [RGB_W-1:0] oRgb;
    logic             texClear;
    logic             texEn;

    // Stage A: line-start detect, pixel position delay and wall capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lineStart <= 1'b0;
            hposD     <= '0;
            visibleD  <= 1'b0;
            sizeR     <= '0;
            sideR     <= 1'b0;
            uR        <= '0;
            wallStart <= '0;
            wallEnd   <= '0;
        end else begin
            lineStart <= bus.hmax;
            hposD     <= bus.hpos;
            visibleD  <= bus.visible;
            if (lineStart) begin
                sizeR     <= bus.i_size;
                sideR     <= bus.i_side;
                uR        <= bus.i_tex;
                wallStart <= (bus.i_size >= H_MID) ? 11'd0 : H_MID - bus.i_size;
                wallEnd   <= (bus.i_size >= H_VIS - H_MID) ? H_VIS : H_MID + bus.i_size;
            end
        end
    end

    assign hposNext = {1'b0, hposD} + 11'd1;

    // Region of the pixel in stage B, and the region the following pixel enters.
    always_comb begin
        region    = state;
        nextState = BLANK;
        if (lineStart || !visibleD) begin
            region = BLANK;
        end else if (state == BLANK && hposD == 10'd0) begin
            if (wallEnd == 11'd0)
                region = FLOOR;
            else if (wallStart == 11'd0)
                region = WALL;
            else
                region = SKY;
        end
        nextState = region;
        case (region)
            SKY:     if (hposNext == wallStart)
                         nextState = (wallStart == wallEnd) ? FLOOR : WALL;
            WALL:    if (hposNext == wallEnd)
                         nextState = FLOOR;
            default: nextState = region;
        endcase
        if (lineStart)
            nextState = BLANK;
    end

    // Restart the texture walk at each line and whenever a wall begins.
    assign texClear = lineStart || (region != WALL && nextState == WALL);
    assign texEn    = (region == WALL);

    tex_stepper uStepper (
        .clk   (clk),
        .reset (reset),
        .clear (texClear),
        .en    (texEn),
        .size  (sizeR),
        .v     (v)
    );

    // Y-side walls are shaded by halving each channel.
    always_comb begin
        t     = uR ^ v;
        texel = sideR ? packRgb({1'b0, t[5]}, {1'b0, t[3]}, 2'b00)
                      : packRgb(t[5:4], t[3:2], 2'b00);
    end

    // Stage B: region FSM with registered colour output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BLANK;
            oRgb  <= '0;
        end else begin
            state <= nextState;
            case (region)
                SKY:     oRgb <= SKY_RGB;
                WALL:    oRgb <= texel;
                FLOOR:   oRgb <= FLOOR_RGB;
                default: oRgb <= '0;
            endcase
        end
    end

    assign bus.o_rgb = oRgb;
    assign bus.state = state;

endmodule

// File: tb/tb_row_render.sv
// Bench for row_render: drives whole scanlines, queues the expected colour
// of every driven pixel and compares it two clocks later.
module tb_row_render;
    import row_render_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    row_render_if bus ();

    row_render dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock generation.
    always #5 clk = ~clk;

    logic [5:0] exp_q[$];
    int         pix_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       drv_tag  = 1'b0;
    logic       tag1     = 1'b0;
    logic       tag2     = 1'b0;

    // Reference colour for pixel h of a line whose wall was captured as given.
    function automatic logic [5:0] exp_pixel(input int h, input int size,
                                             input int side, input int tex);
        int ws, we, v;
        logic [5:0] tt;
        if (h >= 640) return 6'b000000;
        ws = (size >= 320) ? 0 : 320 - size;
        we = (size >= 320) ? 640 : 320 + size;
        if (h < ws) return 6'b010111;
        if (h >= we) return 6'b010101;
        v = (32 * (h - ws)) / size;
        if (v > 63) v = 63;
        tt = 6'(tex) ^ 6'(v);
        if (side == 0) return {tt[5:4], tt[3:2], 2'b00};
        return {1'b0, tt[5], 1'b0, tt[3], 2'b00};
    endfunction

    task automatic check_direct(input string name, input logic [5:0] act, input logic [5:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic check_state(input string name, input region_t req);
        n_checks++;
        if (bus.state !== req) begin
            n_fail++;
            $display("FAIL %s: state got %0d expected %0d", name, bus.state, req);
        end
    endtask

    // Drives one pixel position; tagged pixels are queued for the monitor.
    task automatic drive_pixel(input int h, input logic [5:0] e, input logic tag);
        bus.hpos    = 10'(h);
        bus.visible = (h < 640);
        bus.hmax    = (h == 799);
        drv_tag     = tag;
        if (tag) begin
            exp_q.push_back(e);
            pix_q.push_back(h);
        end
    endtask

    // One full scanline; i_size may be changed mid-line at chg_at.
    task automatic run_line(input int size, input int side, input int tex,
                            input int chg_at, input int chg_size);
        for (int h = 0; h < 800; h++) begin
            @(negedge clk);
            if (h == 0) begin
                bus.i_size = 11'(size);
                bus.i_side = side[0];
                bus.i_tex  = 6'(tex);
            end
            if (h == chg_at) bus.i_size = 11'(chg_size);
            drive_pixel(h, exp_pixel(h, size, side, tex), 1'b1);
        end
    endtask

    // Scanline with reset pulsed at reset_at; output stays 0 for the rest of it.
    task automatic run_reset_line(input int size, input int reset_at);
        for (int h = 0; h < 800; h++) begin
            @(negedge clk);
            if (h == 0) begin
                bus.i_size = 11'(size);
                bus.i_side = 1'b0;
                bus.i_tex  = 6'd0;
            end
            if (h < reset_at - 2) begin
                drive_pixel(h, exp_pixel(h, size, 0, 0), 1'b1);
            end else if (h < reset_at + 4) begin
                drive_pixel(h, 6'd0, 1'b0);
                if (h == reset_at) begin
                    reset = 1'b1;
                    #1;
                    check_direct("async_reset_rgb", bus.o_rgb, 6'd0);
                    check_state("async_reset_state", BLANK);
                end
            end else begin
                if (h == reset_at + 4) reset = 1'b0;
                drive_pixel(h, 6'd0, 1'b1);
                if (h == 700) begin
                    #1;
                    check_state("post_reset_blank", BLANK);
                end
            end
        end
    endtask

    // Output latency tracking: a pixel driven before edge N is due after edge N+1.
    always @(posedge clk) begin
        tag2 <= tag1;
        tag1 <= drv_tag;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (tag2) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: output %b with no expected entry", bus.o_rgb);
            end else begin
                automatic logic [5:0] e = exp_q.pop_front();
                automatic int         p = pix_q.pop_front();
                if (bus.o_rgb !== e) begin
                    n_fail++;
                    $display("FAIL pixel hpos=%0d: got %b expected %b", p, bus.o_rgb, e);
                end
            end
        end
    end

    // Main sequence.
    initial begin
        bus.hpos    = '0;
        bus.hmax    = 1'b0;
        bus.visible = 1'b0;
        bus.i_size  = '0;
        bus.i_side  = 1'b0;
        bus.i_tex   = '0;
        repeat (3) @(negedge clk);
        check_direct("reset_rgb", bus.o_rgb, 6'd0);
        check_state("reset_state", BLANK);
        reset = 1'b0;

        // Tail of a blank line so the first real line gets a line start.
        for (int h = 790; h < 800; h++) begin
            @(negedge clk);
            drive_pixel(h, 6'd0, 1'b1);
        end

        run_line(100, 0, 6'h00, -1, 0);     // sky 0..219, wall 220..419, floor 420..639
        run_reset_line(100, 100);           // async reset mid-line
        run_line(400, 0, 6'h15, -1, 0);     // clipped wall across the whole line
        run_line(0, 0, 6'h2A, -1, 0);       // no wall: sky then floor at 320
        run_line(32, 1, 6'h3F, -1, 0);      // shaded wall, first texel 6'b010100
        run_line(100, 0, 6'h2A, 300, 400);  // mid-line size change is ignored
        run_line(400, 0, 6'h2A, -1, 0);     // new size takes effect after hmax

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_pixel(0, 6'd0, 1'b0);
            bus.visible = 1'b0;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
